// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the ID/EX pipeline slice. This file holds the
//   datapath widths, the bit layout of the decoded control bundle, and the
//   forwarding-source selector used by fwd_mux.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 12;

  // Bit layout of the decoded control bundle.
  localparam int REGWRITE_BIT = 0;
  localparam int ALUSRC_BIT   = 1;
  localparam int MEMWRITE_BIT = 2;
  localparam int MEMREAD_BIT  = 3;
  localparam int ALUOP_LSB    = 4;
  localparam int ALUOP_MSB    = 5;

  // Where an operand comes from after forwarding.
  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_EXM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
//   This block selects one operand after forwarding. Register 0 always reads
//   as zero. The EX/MEM result has priority over the MEM/WB result, and the
//   MEM/WB result has priority over the register file value.
// Ports
//   src_i      source register number
//   rf_data_i  register file read data for src_i
//   exm_*_i    EX/MEM result (write enable, register, data)
//   wb_*_i     MEM/WB result (write enable, register, data)
//   operand_o  forwarded operand
// ---------------------------------------------------------------------------
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              exm_we_i,
  input  logic [REG_AW-1:0] exm_reg_i,
  input  logic [DATA_W-1:0] exm_data_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_reg_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] operand_o
);
  import pipe_pkg::*;

  fwd_sel_e sel_s;

  // Priority select. Because the src_i==0 test comes first, a write to
  // register 0 is never forwarded.
  always_comb begin
    sel_s = FWD_RF;
    if (src_i == {REG_AW{1'b0}}) begin
      sel_s = FWD_ZERO;
    end else if (exm_we_i && (exm_reg_i == src_i)) begin
      sel_s = FWD_EXM;
    end else if (wb_we_i && (wb_reg_i == src_i)) begin
      sel_s = FWD_WB;
    end else begin
      sel_s = FWD_RF;
    end
  end

  // Operand data mux.
  always_comb begin
    operand_o = rf_data_i;
    case (sel_s)
      FWD_ZERO: operand_o = {DATA_W{1'b0}};
      FWD_EXM:  operand_o = exm_data_i;
      FWD_WB:   operand_o = wb_data_i;
      FWD_RF:   operand_o = rf_data_i;
      default:  operand_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   This is the ID/EX pipeline register. It sits directly after the register
//   file read ports. It captures the forwarded operands, the sign-extended
//   immediate, the destination register and the control bundle. It detects
//   load-use hazards and inserts one bubble for each. It uses a valid/ready
//   handshake on both sides and keeps a saturating stall counter.
// Ports
//   clk, reset                 clock, async active-low reset
//   id_valid/id_ready          decode-side handshake
//   id_rs/id_rt/id_uses_rt     source registers, rt-is-a-source flag
//   id_rd/id_imm/id_ctrl       destination, raw immediate, control bundle
//   rf_data_1/rf_data_2        register file read data (rs, rt)
//   exm_*, wb_*                forwarding sources
//   flush                      squash held and offered instruction
//   ex_valid/ex_ready          execute-side handshake
//   ex_op_a/ex_op_b/ex_imm     registered operands and immediate
//   ex_rd/ex_ctrl              registered destination and control
//   stall_cnt                  saturating stall-cycle counter
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CTRL_W      = 12,
  parameter int MEMREAD_BIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [15:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  input  logic              exm_we,
  input  logic [REG_AW-1:0] exm_reg,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       stall_cnt
);

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_op_a_q,  ex_op_a_d;
  logic [DATA_W-1:0] ex_op_b_q,  ex_op_b_d;
  logic [DATA_W-1:0] ex_imm_q,   ex_imm_d;
  logic [REG_AW-1:0] ex_rd_q,    ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [31:0]       stall_q,    stall_d;

  logic [DATA_W-1:0] fwd_a_s, fwd_b_s;
  logic              hazard_s;
  logic              accept_s;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .src_i(id_rs), .rf_data_i(rf_data_1),
    .exm_we_i(exm_we), .exm_reg_i(exm_reg), .exm_data_i(exm_data),
    .wb_we_i(wb_we), .wb_reg_i(wb_reg), .wb_data_i(wb_data),
    .operand_o(fwd_a_s)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .src_i(id_rt), .rf_data_i(rf_data_2),
    .exm_we_i(exm_we), .exm_reg_i(exm_reg), .exm_data_i(exm_data),
    .wb_we_i(wb_we), .wb_reg_i(wb_reg), .wb_data_i(wb_data),
    .operand_o(fwd_b_s)
  );

  // Load-use hazard. A load in EX whose result an offered source needs.
  // The check against rt applies only when rt is a real source.
  always_comb begin
    hazard_s = ex_valid_q && ex_ctrl_q[MEMREAD_BIT] &&
               (ex_rd_q != {REG_AW{1'b0}}) &&
               ((ex_rd_q == id_rs) || (id_uses_rt && (ex_rd_q == id_rt)));
    id_ready = (!ex_valid_q || ex_ready) && !hazard_s;
    // flush discards any transfer, even though id_ready is still reported.
    accept_s = id_valid && id_ready && !flush;
  end

  // Next-state logic for the EX register. flush has priority, then accept,
  // then hold. Otherwise the slot drains.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_a_d  = ex_op_a_q;
    ex_op_b_d  = ex_op_b_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    ex_ctrl_d  = ex_ctrl_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept_s) begin
      ex_valid_d = 1'b1;
      ex_op_a_d  = fwd_a_s;
      ex_op_b_d  = fwd_b_s;
      ex_imm_d   = {{(DATA_W-16){id_imm[15]}}, id_imm};
      ex_rd_d    = id_rd;
      ex_ctrl_d  = id_ctrl;
    end else if (ex_valid_q && !ex_ready) begin
      // Hold without re-forwarding. The captured operands stay as they are.
      ex_valid_d = 1'b1;
    end else begin
      // Consumed or empty with nothing accepted. This is also the hazard bubble.
      ex_valid_d = 1'b0;
    end
  end

  // Stall counter. Flushed cycles are not counted. It saturates at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (id_valid && !id_ready && !flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers. Reset drops any held instruction at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_op_a_q  <= {DATA_W{1'b0}};
      ex_op_b_q  <= {DATA_W{1'b0}};
      ex_imm_q   <= {DATA_W{1'b0}};
      ex_rd_q    <= {REG_AW{1'b0}};
      ex_ctrl_q  <= {CTRL_W{1'b0}};
      stall_q    <= 32'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_a_q  <= ex_op_a_d;
      ex_op_b_q  <= ex_op_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
      stall_q    <= stall_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_op_a   = ex_op_a_q;
  assign ex_op_b   = ex_op_b_q;
  assign ex_imm    = ex_imm_q;
  assign ex_rd     = ex_rd_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign stall_cnt = stall_q;

endmodule
